// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// The quotient is resolved one bit per clock, MSB first, and a start/busy/done
// handshake frames each operation. A zero divisor completes after a single
// cycle with quo all-ones, rem zero and dz set.
// Optional macro DIV_SELFCHECK_EN adds a completion check. It verifies that
// quo*divisor + rem matches the dividend and that rem < divisor. Any
// violation latches into err, and err stays set until reset.
module seq_divider #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [WIDTH_A-1:0] dividend,
    input  logic [WIDTH_B-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] quo,
    output logic [WIDTH_B-1:0] rem,
    output logic               dz,
    output logic               err
);

    localparam int CW = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH_A-1:0] qw;    // dividend bits shift out the top, quotient bits shift in at the bottom
    logic [WIDTH_B:0]   prem;  // partial remainder, one bit wider than the divisor
    logic [WIDTH_B-1:0] dvs;

    logic [WIDTH_B:0]   shifted;
    logic [WIDTH_B:0]   trial;
    logic               fits;
    logic [WIDTH_B:0]   prem_nx;
    logic [WIDTH_A-1:0] qw_nx;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
    always_comb begin
        shifted = (prem << 1) | {{WIDTH_B{1'b0}}, qw[WIDTH_A-1]};
        fits    = (shifted >= {1'b0, dvs});
        trial   = shifted - {1'b0, dvs};
        prem_nx = fits ? trial : shifted;
        qw_nx   = {qw[WIDTH_A-2:0], fits};
    end

`ifdef DIV_SELFCHECK_EN
    localparam int PW = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0] dvd;
    logic [PW-1:0]      chk_sum;
    logic               chk_bad;

    // Recombine the finishing result against the captured operands
    always_comb begin
        chk_sum = PW'(qw_nx) * PW'(dvs) + PW'(prem_nx[WIDTH_B-1:0]);
        chk_bad = (chk_sum != PW'(dvd)) || (prem_nx[WIDTH_B-1:0] >= dvs);
    end

    // Capture the dividend and latch any check failure (sticky)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dvd <= '0;
            err <= 1'b0;
        end else begin
            if (state == IDLE && start)
                dvd <= dividend;
            if (state == CALC && dvs != '0 && cnt == '0 && chk_bad)
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            qw    <= '0;
            prem  <= '0;
            dvs   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        qw    <= dividend;
                        dvs   <= divisor;
                        prem  <= '0;
                        cnt   <= CW'(WIDTH_A - 1);
                    end
                end
                CALC: begin
                    if (dvs == '0) begin
                        // Divide by zero: finish right away with the saturated quotient
                        state <= DONE;
                        done  <= 1'b1;
                        quo   <= '1;
                        rem   <= '0;
                        dz    <= 1'b1;
                    end else begin
                        qw   <= qw_nx;
                        prem <= prem_nx;
                        cnt  <= cnt - CW'(1);
                        if (cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            quo   <= qw_nx;
                            rem   <= prem_nx[WIDTH_B-1:0];
                            dz    <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider. It runs a table of operand/result vectors,
// then hand-written sequences for ignored start, mid-operation reset and
// product round-trips.
module tb_seq_divider;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, dz, err;
    logic [7:0] quo;
    logic [3:0] rem;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] prev_q = '0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t tbl[6];

    seq_divider #(.WIDTH_A(8), .WIDTH_B(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quo(quo), .rem(rem), .dz(dz), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one operation and check handshake timing plus results
    task automatic run_op(input string nm, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz);
        int lat;
        bit seen;
        @(negedge CLK);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 4'h3;
        check({nm, "_busy_acc"}, busy, 1);
        check({nm, "_quo_hold"}, quo, prev_q);
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                seen = 1;
                lat  = i;
            end
        end
        check({nm, "_latency"}, lat, (b == 0) ? 1 : 8);
        if (seen) begin
            check({nm, "_quo"}, quo, eq);
            check({nm, "_rem"}, rem, er);
            check({nm, "_dz"}, dz, edz);
            check({nm, "_busy_done"}, busy, 1);
            @(posedge CLK);
            #1;
            check({nm, "_busy_after"}, busy, 0);
            check({nm, "_done_after"}, done, 0);
        end
        prev_q = eq;
    endtask

    initial begin
        int dcnt;
        tbl[0] = '{8'd143, 4'd11, 8'd13,  4'd0, 1'b0};
        tbl[1] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        tbl[2] = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0};
        tbl[3] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
        tbl[4] = '{8'd9,   4'd0,  8'hFF,  4'd0, 1'b1};
        tbl[5] = '{8'd100, 4'd9,  8'd11,  4'd1, 1'b0};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quo", quo, 0);
        check("rst_rem", rem, 0);
        check("rst_dz", dz, 0);
        check("rst_err", err, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

        // A second start issued while busy must be ignored
        @(negedge CLK);
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        dcnt  = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge CLK);
            if (i == 3) begin
                dividend = 8'd99;
                divisor  = 4'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK);
            #1;
            if (done) dcnt++;
        end
        check("ign_done_cnt", dcnt, 1);
        check("ign_quo", quo, 10);
        check("ign_rem", rem, 0);
        check("ign_busy", busy, 0);
        prev_q = 8'd10;

        // Asynchronous reset in the middle of an operation
        @(negedge CLK);
        dividend = 8'd143;
        divisor  = 4'd11;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 4; i++) @(posedge CLK);
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_quo", quo, 0);
        check("mid_rst_rem", rem, 0);
        check("mid_rst_dz", dz, 0);
        @(negedge CLK);
        RST_N  = 1'b1;
        prev_q = '0;
        run_op("post_rst", 8'd60, 4'd4, 8'd15, 4'd0, 1'b0);

        // Multiplier products divided back into their operands
        for (int i = 0; i < 20; i++) begin
            int a, b;
            a = $urandom_range(1, 15);
            b = $urandom_range(1, 15);
            run_op($sformatf("prod%0d_%0dx%0d", i, a, b), 8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0);
        end
        check("err_final", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
